// File: rtl/nwcc_gate_readout.sv
// ---------------------------------------------------------------------------
// nwcc_gate_readout
//
// Measurement-gate and readout stage behind the neutron coincidence counter.
// It double-samples the free-running total, R+A and A counters. Over a
// counting gate of GATE_US cycles it accumulates their modular increments.
// It then presents the per-gate sums on a valid/ready interface. The block
// supports single-shot and back-to-back (continuous) gates, abort, and
// overrun detection.
//
// Build option:
//   NWCC_GATE_SAT_EN  defined   : each accumulator saturates at 2^AW-1, and
//                                 o_sat flags a result where any channel
//                                 saturated during that gate.
//                     undefined : accumulators wrap mod 2^AW, o_sat is 0.
//
// Ports:
//   i_clk_1mhz, i_reset_n       clock, asynchronous active-low reset
//   i_total_count               total pulse counter (CW bits, free-running)
//   i_r_plus_a_count            R+A accumulator (CW bits, free-running)
//   i_a_count                   A accumulator (CW bits, free-running)
//   i_start                     one-cycle pulse, starts a gate from IDLE
//   i_abort                     cancels the gate in progress, no result
//   i_continuous                at gate end, start the next gate immediately
//   i_ready                     host accepts the presented result
//   o_valid                     result available
//   o_total_sum/o_rpa_sum/o_a_sum  per-gate sums (AW bits)
//   o_gate_id                   index of the gate carried by the result
//   o_sat                       some sum of this result saturated
//   o_overrun                   sticky, a completed gate was dropped
//   o_busy                      gate armed or running
// ---------------------------------------------------------------------------
module nwcc_gate_readout #(
  parameter int GATE_US = 4096,
  parameter int CW      = 13,
  parameter int AW      = 24
) (
  input  logic          i_clk_1mhz,
  input  logic          i_reset_n,
  input  logic [CW-1:0] i_total_count,
  input  logic [CW-1:0] i_r_plus_a_count,
  input  logic [CW-1:0] i_a_count,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_continuous,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [AW-1:0] o_total_sum,
  output logic [AW-1:0] o_rpa_sum,
  output logic [AW-1:0] o_a_sum,
  output logic [7:0]    o_gate_id,
  output logic          o_sat,
  output logic          o_overrun,
  output logic          o_busy
);

  localparam int NCH = 3;
  localparam int GCW = $clog2(GATE_US);
  localparam logic [GCW-1:0] LAST = GCW'(GATE_US - 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

  state_t         state;
  logic [GCW-1:0] cyc;
  logic [7:0]     gate_id;

  logic [CW-1:0]  din     [NCH];
  logic [CW-1:0]  s1      [NCH];
  logic [CW-1:0]  s2      [NCH];
  logic [CW-1:0]  prev    [NCH];
  logic [CW-1:0]  delta   [NCH];
  logic [AW-1:0]  acc     [NCH];
  logic [AW-1:0]  acc_nxt [NCH];
  logic [NCH-1:0] stable;
  logic [NCH-1:0] loaded;

  logic gate_end;

`ifdef NWCC_GATE_SAT_EN
  // The sum is formed wider than both operands. A full CW-bit delta can
  // then push a narrow accumulator into saturation, not wrap it.
  localparam int SW = ((AW > CW) ? AW : CW) + 1;
  localparam logic [AW-1:0] AMAX = '1;
  logic [SW-1:0]  sum_w [NCH];
  logic [NCH-1:0] ovf;
  logic           sat_acc;
`endif

  assign din[0] = i_total_count;
  assign din[1] = i_r_plus_a_count;
  assign din[2] = i_a_count;

  assign o_busy   = (state != IDLE);
  assign gate_end = (state == RUN) && (cyc == LAST) && !i_abort;

  // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      stable[c] = (s1[c] == s2[c]);
      // Modular difference absorbs the counter wrap 2^CW-1 -> 0.
      delta[c]  = s2[c] - prev[c];
`ifdef NWCC_GATE_SAT_EN
      sum_w[c] = SW'(acc[c]) + SW'(delta[c]);
      ovf[c]   = stable[c] && (sum_w[c] > SW'(AMAX));
      if (!stable[c])  acc_nxt[c] = acc[c];
      else if (ovf[c]) acc_nxt[c] = AMAX;
      else             acc_nxt[c] = sum_w[c][AW-1:0];
`else
      acc_nxt[c] = stable[c] ? acc[c] + AW'(delta[c]) : acc[c];
`endif
    end
  end

  // NOTE: all state here is sequential and uses non-blocking assignments, so every read sees pre-edge values.
  always_ff @(posedge i_clk_1mhz or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: these per-channel arrays are a handful of flops, not RAM, so they are reset like any other register.
      for (int c = 0; c < NCH; c++) begin
        s1[c]   <= '0;
        s2[c]   <= '0;
        prev[c] <= '0;
        acc[c]  <= '0;
      end
      state       <= IDLE;
      loaded      <= '0;
      cyc         <= '0;
      gate_id     <= '0;
      o_valid     <= 1'b0;
      o_total_sum <= '0;
      o_rpa_sum   <= '0;
      o_a_sum     <= '0;
      o_gate_id   <= '0;
      o_overrun   <= 1'b0;
`ifdef NWCC_GATE_SAT_EN
      o_sat       <= 1'b0;
      sat_acc     <= 1'b0;
`endif
    end else begin
      for (int c = 0; c < NCH; c++) begin
        s1[c] <= din[c];
        s2[c] <= s1[c];
      end

      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= ARM;
            loaded    <= '0;
            o_overrun <= 1'b0;
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
`ifdef NWCC_GATE_SAT_EN
            sat_acc   <= 1'b0;
`endif
          end
        end

        ARM: begin
          cyc <= '0;
          if (i_abort) begin
            state <= IDLE;
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
          end else begin
            // A channel that is mid-transition waits for a stable sample.
            // This keeps the baseline from latching a torn counter value.
            for (int c = 0; c < NCH; c++)
              if (stable[c]) prev[c] <= s2[c];
            loaded <= loaded | stable;
            if (&(loaded | stable)) state <= RUN;
          end
        end

        RUN: begin
          if (i_abort) begin
            state <= IDLE;
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
`ifdef NWCC_GATE_SAT_EN
            sat_acc <= 1'b0;
`endif
          end else begin
            for (int c = 0; c < NCH; c++)
              if (stable[c]) prev[c] <= s2[c];
            if (cyc == LAST) begin
              // prev is kept so back-to-back gates miss no counts.
              if (i_continuous) begin
                cyc <= '0;
                for (int c = 0; c < NCH; c++) acc[c] <= '0;
`ifdef NWCC_GATE_SAT_EN
                sat_acc <= 1'b0;
`endif
              end else begin
                state <= IDLE;
              end
            end else begin
              cyc <= cyc + GCW'(1);
              for (int c = 0; c < NCH; c++) acc[c] <= acc_nxt[c];
`ifdef NWCC_GATE_SAT_EN
              sat_acc <= sat_acc | (|ovf);
`endif
            end
          end
        end

        default: state <= IDLE;
      endcase

      // Result register. A completed gate always consumes a gate id, even
      // when the host is still holding the previous result.
      if (gate_end) begin
        if (!o_valid || i_ready) begin
          o_valid     <= 1'b1;
          o_total_sum <= acc_nxt[0];
          o_rpa_sum   <= acc_nxt[1];
          o_a_sum     <= acc_nxt[2];
          o_gate_id   <= gate_id;
`ifdef NWCC_GATE_SAT_EN
          o_sat       <= sat_acc | (|ovf);
`endif
        end else begin
          o_overrun <= 1'b1;
        end
        gate_id <= gate_id + 8'd1;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifndef NWCC_GATE_SAT_EN
  assign o_sat = 1'b0;
`endif

endmodule

// File: tb/tb_nwcc_gate_readout.sv
// ---------------------------------------------------------------------------
// tb_nwcc_gate_readout
//
// Self-checking bench for nwcc_gate_readout, built with GATE_US=16 and AW=8
// so that gates are short and wrap/saturation are easy to reach.
//
// A behavioural model keeps the last two samples of each counter input. It
// accumulates modular increments per gate as plain integers and tracks the
// gate/result bookkeeping. Every cycle the model is compared with the DUT.
// Directed scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_nwcc_gate_readout;
  localparam int GATE_US = 16;
  localparam int CW      = 13;
  localparam int AW      = 8;
  localparam int MODC    = 1 << CW;
  localparam int MODA    = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] tot = '0, rpa = '0, ac = '0;
  logic          start = 1'b0, abort_g = 1'b0, cont = 1'b0, ready = 1'b0;
  logic          o_valid, o_sat, o_overrun, o_busy;
  logic [AW-1:0] o_total_sum, o_rpa_sum, o_a_sum;
  logic [7:0]    o_gate_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nwcc_gate_readout #(.GATE_US(GATE_US), .CW(CW), .AW(AW)) dut (
    .i_clk_1mhz      (clk),
    .i_reset_n       (rst_n),
    .i_total_count   (tot),
    .i_r_plus_a_count(rpa),
    .i_a_count       (ac),
    .i_start         (start),
    .i_abort         (abort_g),
    .i_continuous    (cont),
    .i_ready         (ready),
    .o_valid         (o_valid),
    .o_total_sum     (o_total_sum),
    .o_rpa_sum       (o_rpa_sum),
    .o_a_sum         (o_a_sum),
    .o_gate_id       (o_gate_id),
    .o_sat           (o_sat),
    .o_overrun       (o_overrun),
    .o_busy          (o_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_ARM, M_RUN} mphase_t;
  mphase_t m_phase;
  int  h_new[3], h_old[3];        // most recent and previous input samples
  int  m_prev[3], m_sum[3];
  bit  m_loaded[3];
  bit  m_satf;
  int  m_left, m_gid;
  bit  r_valid, r_over, r_sat;
  int  r_sum[3], r_gid;

  function automatic int cur_in(input int c);
    case (c)
      0:       return int'(tot);
      1:       return int'(rpa);
      default: return int'(ac);
    endcase
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE;
    for (int c = 0; c < 3; c++) begin
      h_new[c] = 0; h_old[c] = 0; m_prev[c] = 0; m_sum[c] = 0;
      m_loaded[c] = 0; r_sum[c] = 0;
    end
    m_satf = 0; m_left = 0; m_gid = 0;
    r_valid = 0; r_over = 0; r_sat = 0; r_gid = 0;
  endtask

  task automatic model_step();
    bit st[3];
    bit ge;
    int d, s;
    for (int c = 0; c < 3; c++) st[c] = (h_new[c] == h_old[c]);
    ge = (m_phase == M_RUN) && !abort_g && (m_left == 1);

    if (m_phase == M_RUN && !abort_g) begin
      for (int c = 0; c < 3; c++) begin
        if (st[c]) begin
          d = (h_new[c] - m_prev[c] + MODC) % MODC;
          s = m_sum[c] + d;
`ifdef NWCC_GATE_SAT_EN
          if (s > MODA - 1) begin s = MODA - 1; m_satf = 1; end
`else
          s = s % MODA;
`endif
          m_sum[c]  = s;
          m_prev[c] = h_new[c];
        end
      end
    end

    if (ge) begin
      if (!r_valid || ready) begin
        r_valid = 1; r_gid = m_gid; r_sat = m_satf;
        for (int c = 0; c < 3; c++) r_sum[c] = m_sum[c];
      end else begin
        r_over = 1;
      end
      m_gid = (m_gid + 1) % 256;
    end else if (r_valid && ready) begin
      r_valid = 0;
    end

    case (m_phase)
      M_IDLE: if (start) begin
        m_phase = M_ARM; m_satf = 0; r_over = 0;
        for (int c = 0; c < 3; c++) begin m_sum[c] = 0; m_loaded[c] = 0; end
      end
      M_ARM: if (abort_g) begin
        m_phase = M_IDLE;
        for (int c = 0; c < 3; c++) m_sum[c] = 0;
      end else begin
        for (int c = 0; c < 3; c++)
          if (st[c]) begin m_prev[c] = h_new[c]; m_loaded[c] = 1; end
        if (m_loaded[0] && m_loaded[1] && m_loaded[2]) begin
          m_phase = M_RUN; m_left = GATE_US;
        end
      end
      M_RUN: if (abort_g) begin
        m_phase = M_IDLE; m_satf = 0;
        for (int c = 0; c < 3; c++) m_sum[c] = 0;
      end else if (ge) begin
        if (cont) begin
          m_left = GATE_US; m_satf = 0;
          for (int c = 0; c < 3; c++) m_sum[c] = 0;
        end else begin
          m_phase = M_IDLE;
        end
      end else begin
        m_left--;
      end
      default: m_phase = M_IDLE;
    endcase

    for (int c = 0; c < 3; c++) begin
      h_old[c] = h_new[c];
      h_new[c] = cur_in(c);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", o_valid, r_valid);
      check("busy", o_busy, m_phase != M_IDLE);
      check("overrun", o_overrun, r_over);
      if (r_valid) begin
        check("total_sum", o_total_sum, r_sum[0]);
        check("rpa_sum", o_rpa_sum, r_sum[1]);
        check("a_sum", o_a_sum, r_sum[2]);
        check("gate_id", o_gate_id, r_gid);
        check("sat", o_sat, r_sat);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int t0, input int r0, input int a0);
    @(negedge clk);
    rst_n = 1'b0;
    start = 0; abort_g = 0; cont = 0; ready = 0;
    tot = CW'(t0); rpa = CW'(r0); ac = CW'(a0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int max, input string nm);
    int k;
    k = 0;
    while (!o_valid && k < max) begin
      tick(1);
      k++;
    end
    check({nm, " valid seen"}, o_valid, 1);
  endtask

  int seen;
  logic [CW-1:0] base [3];
  int ready_mode;

  initial begin
    // Reset state.
    tick(1);
    check("reset valid", o_valid, 0);
    check("reset busy", o_busy, 0);
    check("reset overrun", o_overrun, 0);
    check("reset sums", {o_total_sum, o_rpa_sum, o_a_sum}, 0);
    check("reset gate_id", o_gate_id, 0);
    check("reset sat", o_sat, 0);

    // Single gate: 100->110, 0->50, 0->20.
    do_reset(100, 0, 0);
    ready = 1'b1;
    pulse_start();
    tick(5);
    tot = 13'd110; rpa = 13'd50; ac = 13'd20;
    wait_valid(40, "single");
    check("single total", o_total_sum, 10);
    check("single rpa", o_rpa_sum, 50);
    check("single a", o_a_sum, 20);
    check("single id", o_gate_id, 0);
    tick(3);
    check("single valid drops", o_valid, 0);

    // Counter wrap: 8190 -> 8191 -> 0 -> 5.
    do_reset(8190, 0, 0);
    ready = 1'b1;
    pulse_start();
    tick(4);
    tot = 13'd8191; tick(1);
    tot = 13'd0;    tick(1);
    tot = 13'd5;
    wait_valid(40, "wrap");
    check("wrap total", o_total_sum, 7);
    check("wrap id", o_gate_id, 0);

    // Continuous gates with the host stalled: overrun, then id 2.
    do_reset(0, 0, 0);
    cont = 1'b1; ready = 1'b0;
    pulse_start();
    tot = 13'd3;
    wait_valid(40, "cont first");
    check("cont first id", o_gate_id, 0);
    check("cont first total", o_total_sum, 3);
    repeat (GATE_US) @(posedge clk);
    @(negedge clk);
    check("cont overrun", o_overrun, 1);
    check("cont held valid", o_valid, 1);
    check("cont held id", o_gate_id, 0);
    ready = 1'b1; cont = 1'b0;
    tick(1);
    check("cont valid after accept", o_valid, 0);
    wait_valid(40, "cont third");
    check("cont third id", o_gate_id, 2);

    // Abort on RUN cycle 5; the next result still carries id 0.
    do_reset(0, 0, 0);
    ready = 1'b1;
    pulse_start();
    tot = 13'd9;
    tick(6);
    abort_g = 1'b1; tick(1); abort_g = 1'b0;
    seen = 0;
    for (int i = 0; i < GATE_US + 8; i++) begin
      seen |= int'(o_valid);
      tick(1);
    end
    check("abort no result", seen, 0);
    check("abort idle", o_busy, 0);
    pulse_start();
    tot = 13'd12;
    wait_valid(40, "after abort");
    check("after abort id", o_gate_id, 0);
    check("after abort total", o_total_sum, 3);

    // Unstable input toggling, then settling at +40.
    do_reset(0, 0, 0);
    ready = 1'b1;
    pulse_start();
    tick(3);
    for (int i = 0; i < 8; i++) begin
      tot = (i % 2) ? 13'd7 : 13'd3;
      tick(1);
    end
    tot = 13'd40;
    wait_valid(40, "unstable");
    check("unstable total", o_total_sum, 40);

    // R+A grows by 300 within one gate of an 8-bit accumulator.
    do_reset(0, 0, 0);
    ready = 1'b1;
    pulse_start();
    tick(4);
    rpa = 13'd300;
    wait_valid(40, "sat");
`ifdef NWCC_GATE_SAT_EN
    check("sat rpa", o_rpa_sum, 255);
    check("sat flag", o_sat, 1);
`else
    check("wrap rpa", o_rpa_sum, 44);
    check("sat flag", o_sat, 0);
`endif

    // Randomized traffic checked by the model. It includes glitchy inputs,
    // host stalls, aborts, a gate-id wrap and one reset in mid-traffic.
    do_reset(0, 0, 0);
    for (int c = 0; c < 3; c++) base[c] = '0;
    ready_mode = 0;
    for (int i = 0; i < 8000; i++) begin
      if (i == 7000) do_reset(int'(base[0]), int'(base[1]), int'(base[2]));
      @(negedge clk);
      if (i % 200 == 0) ready_mode = $urandom_range(0, 2);
      start   = ($urandom_range(0, 9) == 0);
      abort_g = ($urandom_range(0, 149) == 0);
      cont    = ($urandom_range(0, 3) != 0);
      ready   = (ready_mode == 0) ? ($urandom_range(0, 19) == 0)
                                  : ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, 3) == 0) base[c] = base[c] + CW'($urandom_range(0, 150));
      tot = ($urandom_range(0, 9) == 0) ? CW'($urandom) : base[0];
      rpa = ($urandom_range(0, 9) == 0) ? CW'($urandom) : base[1];
      ac  = ($urandom_range(0, 9) == 0) ? CW'($urandom) : base[2];
    end
    start = 0; abort_g = 0; cont = 0; ready = 1;
    tick(GATE_US + 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
